handshake_gather6: RTL and testbench



---
 rtl/gather_pkg.sv | 9 +
 rtl/handshake_gather6.sv | 93 +++++++++
 tb/tb_handshake_gather6.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gather_pkg.sv
// Shared constants and types for the six-lane stream gatherer.
package gather_pkg;

   localparam int GROUP_SIZE = 6;

   typedef logic [2:0] lane_idx_t;
   typedef logic [2:0] count_t;

endpackage

// File: rtl/handshake_gather6.sv
// Packs a serial valid/ready word stream into six-lane bundles for the
// adder tree; short groups closed by i_last are zero-padded.
module handshake_gather6
   import gather_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   output logic                  o_rdy,
   output logic                  o_vld,
   input  logic                  i_rdy,
   output logic [DATA_WIDTH-1:0] o_a,
   output logic [DATA_WIDTH-1:0] o_b,
   output logic [DATA_WIDTH-1:0] o_c,
   output logic [DATA_WIDTH-1:0] o_d,
   output logic [DATA_WIDTH-1:0] o_e,
   output logic [DATA_WIDTH-1:0] o_f,
   output count_t                o_cnt
);

   localparam lane_idx_t LAST_IDX = lane_idx_t'(GROUP_SIZE - 1);

   logic [DATA_WIDTH-1:0] col_q  [GROUP_SIZE];
   logic [DATA_WIDTH-1:0] out_q  [GROUP_SIZE];
   logic [DATA_WIDTH-1:0] bundle [GROUP_SIZE];
   lane_idx_t             cnt_q;
   logic                  pend_q;
   logic                  take;
   logic                  done;
   logic                  out_free;
   logic                  load;

   assign o_rdy    = ~rst & ~pend_q;
   assign take     = i_vld & o_rdy;
   assign done     = take & (i_last | (cnt_q == LAST_IDX));
   assign out_free = ~o_vld | i_rdy;
   assign load     = out_free & (pend_q | done);

   // Lane cnt_q holds the completing word: bypassed live, or parked while pend.
   always_comb begin
      for (int k = 0; k < GROUP_SIZE; k++) begin
         bundle[k] = '0;
         if (lane_idx_t'(k) < cnt_q)
            bundle[k] = col_q[k];
         else if (lane_idx_t'(k) == cnt_q)
            bundle[k] = pend_q ? col_q[k] : i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_vld  <= 1'b0;
         o_cnt  <= '0;
         cnt_q  <= '0;
         pend_q <= 1'b0;
         for (int k = 0; k < GROUP_SIZE; k++) begin
            out_q[k] <= '0;
            col_q[k] <= '0;
         end
      end else begin
         if (take)
            col_q[cnt_q] <= i_data;

         if (load) begin
            o_vld  <= 1'b1;
            o_cnt  <= count_t'(cnt_q + 3'd1);
            cnt_q  <= '0;
            pend_q <= 1'b0;
            for (int k = 0; k < GROUP_SIZE; k++)
               out_q[k] <= bundle[k];
         end else begin
            if (i_rdy)
               o_vld <= 1'b0;
            if (done)
               pend_q <= 1'b1;
            else if (take)
               cnt_q <= cnt_q + 3'd1;
         end
      end
   end

   assign o_a = out_q[0];
   assign o_b = out_q[1];
   assign o_c = out_q[2];
   assign o_d = out_q[3];
   assign o_e = out_q[4];
   assign o_f = out_q[5];

endmodule

// File: tb/tb_handshake_gather6.sv
// Scoreboard bench for handshake_gather6: directed scenarios plus a
// randomized stream checked against a word-grouping reference model.
module tb_handshake_gather6;

   typedef struct packed {
      logic [5:0][31:0] l;
      logic [2:0]       cnt;
   } bund_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_vld;
   logic [31:0] i_data;
   logic        i_last;
   logic        o_rdy;
   logic        o_vld;
   logic        i_rdy;
   logic [31:0] o_a, o_b, o_c, o_d, o_e, o_f;
   logic [2:0]  o_cnt;

   logic [5:0][31:0] dl;
   logic [5:0][31:0] snap;
   logic [2:0]       snap_cnt;

   bund_t       exp_q[$];
   logic [31:0] grp[$];

   int  errors = 0;
   int  checks = 0;
   bit  rnd = 0;
   bit  hold_chk = 0;
   bit  lat_chk = 0;
   bit  pend_chk = 0;

   assign dl = {o_f, o_e, o_d, o_c, o_b, o_a};

   always #5 clk = ~clk;

   handshake_gather6 #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (i_vld),
      .i_data (i_data),
      .i_last (i_last),
      .o_rdy  (o_rdy),
      .o_vld  (o_vld),
      .i_rdy  (i_rdy),
      .o_a    (o_a),
      .o_b    (o_b),
      .o_c    (o_c),
      .o_d    (o_d),
      .o_e    (o_e),
      .o_f    (o_f),
      .o_cnt  (o_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd)
         i_rdy = ($urandom_range(0, 2) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Present one word and hold it until the DUT takes it.
   task automatic send(input logic [31:0] d, input bit last);
      i_vld  = 1'b1;
      i_data = d;
      i_last = last;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (o_rdy)
            break;
         if (t > 200) begin
            chk("send_timeout", 0, 1);
            break;
         end
         tick();
      end
      tick();
      i_vld  = 1'b0;
      i_last = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200; t++) begin
         if (exp_q.size() == 0 && !o_vld)
            break;
         tick();
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Reference model and output checker, sampled on the falling edge.
   task automatic monitor();
      bund_t b;
      forever begin
         @(negedge clk);
         if (hold_chk) begin
            chk("hold_vld", o_vld, 1);
            chk("hold_lanes", dl == snap, 1);
            chk("hold_cnt", o_cnt, snap_cnt);
         end
         if (lat_chk)
            chk("latency_vld", o_vld, 1);
         if (pend_chk)
            chk("pend_rdy_low", o_rdy, 0);
         hold_chk = 0;
         lat_chk  = 0;
         pend_chk = 0;
         if (rst) begin
            grp.delete();
            exp_q.delete();
         end else begin
            if (o_vld && i_rdy) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_bundle", 1, 0);
               end else begin
                  b = exp_q.pop_front();
                  chk("o_cnt", o_cnt, b.cnt);
                  for (int j = 0; j < 6; j++)
                     chk($sformatf("lane%0d", j), dl[j], b.l[j]);
               end
            end
            if (o_vld && !i_rdy) begin
               hold_chk = 1;
               snap     = dl;
               snap_cnt = o_cnt;
            end
            if (i_vld && o_rdy) begin
               grp.push_back(i_data);
               if (grp.size() == 6 || i_last) begin
                  b = '0;
                  foreach (grp[j])
                     b.l[j] = grp[j];
                  b.cnt = 3'(grp.size());
                  exp_q.push_back(b);
                  grp.delete();
                  if (!o_vld || i_rdy)
                     lat_chk = 1;
                  else
                     pend_chk = 1;
               end
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      i_vld  = 1'b1;
      i_data = 32'h5555_AAAA;
      i_last = 1'b1;
      i_rdy  = 1'b1;
      fork
         monitor();
      join_none

      // Reset state; the word offered during reset must be ignored.
      idle(2);
      @(negedge clk);
      chk("rst_rdy_low", o_rdy, 0);
      chk("rst_vld", o_vld, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_lanes", dl, 0);
      tick();
      i_vld  = 1'b0;
      i_last = 1'b0;
      rst    = 1'b0;
      tick();
      @(negedge clk);
      chk("post_rst_vld", o_vld, 0);
      chk("post_rst_rdy", o_rdy, 1);

      // Two full groups streamed back to back.
      tick();
      for (int w = 1; w <= 12; w++) begin
         send(32'(w), 1'b0);
         chk("t1_rdy_high", o_rdy, 1);
      end
      wait_drain();

      // Short group, then a single-word group at lane a.
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      send(32'd30, 1'b1);
      send(32'hDEADBEEF, 1'b1);
      wait_drain();

      // Downstream stalled: second group parks in pend.
      i_rdy = 1'b0;
      for (int w = 1; w <= 12; w++)
         send(32'(w), 1'b0);
      @(negedge clk);
      chk("t3_rdy_low", o_rdy, 0);
      chk("t3_hold_a", o_a, 1);
      chk("t3_hold_f", o_f, 6);
      tick();
      i_rdy = 1'b1;
      tick();
      i_rdy = 1'b0;
      @(negedge clk);
      chk("t3_next_vld", o_vld, 1);
      chk("t3_next_a", o_a, 7);
      chk("t3_next_f", o_f, 12);
      chk("t3_rdy_back", o_rdy, 1);
      tick();
      i_rdy = 1'b1;
      wait_drain();

      // Reset mid-group discards the partial group.
      for (int w = 1; w <= 4; w++)
         send(32'(w + 50), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_vld", o_vld, 0);
      chk("t5_cnt", o_cnt, 0);
      tick();
      for (int w = 100; w <= 105; w++)
         send(32'(w), 1'b0);
      wait_drain();

      // Randomized stream with random stalls and early closes.
      rnd = 1;
      for (int w = 0; w < 600; w++) begin
         idle($urandom_range(0, 2));
         send($urandom, $urandom_range(0, 4) == 0);
      end
      send($urandom, 1'b1);
      rnd   = 0;
      i_rdy = 1'b1;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
